// File: rtl/ext_int_controller.sv
// -----------------------------------------------------------------------------
// ext_int_controller
//
// Collects one-cycle interrupt_request pulses from the per-pin external
// interrupt handlers. Each source gets a pending flag and a sticky overrun
// flag. The controller applies the mask and the global enable, picks the
// highest-priority eligible source (lowest index wins) and presents it to the
// CPU core over an irq / ack / eoi handshake. Interrupts do not nest: a new
// source is dispatched only after the current ISR signals end of interrupt.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   int_req        one-cycle request pulses, one bit per source
//   global_enable  master interrupt enable (CPU status bit)
//   int_mask       1 = source may be dispatched (pending latches regardless)
//   clear_pending  software clear of pending and overrun, one pulse per bit
//   cpu_ack        CPU accepts the presented interrupt
//   cpu_eoi        CPU finished the ISR
//   irq            interrupt request to the CPU (registered)
//   irq_vector     index of the presented / in-service source (registered)
//   pending        pending flags (registered)
//   overrun        sticky lost-request flags (registered)
//   in_service     high while an ISR is active (registered)
// -----------------------------------------------------------------------------
module ext_int_controller #(
   parameter int NUM_SOURCES  = 4,
   parameter int VECTOR_WIDTH = $clog2(NUM_SOURCES)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_SOURCES-1:0]  int_req,
   input  logic                    global_enable,
   input  logic [NUM_SOURCES-1:0]  int_mask,
   input  logic [NUM_SOURCES-1:0]  clear_pending,
   input  logic                    cpu_ack,
   input  logic                    cpu_eoi,
   output logic                    irq,
   output logic [VECTOR_WIDTH-1:0] irq_vector,
   output logic [NUM_SOURCES-1:0]  pending,
   output logic [NUM_SOURCES-1:0]  overrun,
   output logic                    in_service
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    irq_q, irq_d;
   logic [VECTOR_WIDTH-1:0] irq_vector_q, irq_vector_d;
   logic [NUM_SOURCES-1:0]  pending_q, pending_d;
   logic [NUM_SOURCES-1:0]  overrun_q, overrun_d;
   logic                    in_service_q, in_service_d;

   logic [NUM_SOURCES-1:0]  vec_onehot;
   logic [NUM_SOURCES-1:0]  clr_vec;
   logic [NUM_SOURCES-1:0]  eligible;
   logic [VECTOR_WIDTH-1:0] prio_idx;
   logic                    ack_fire;
   logic                    withdraw;

   // ---------------------------------------------------------------------------
   // Pending / overrun bookkeeping
   // ---------------------------------------------------------------------------
   always_comb begin
      vec_onehot = NUM_SOURCES'(1) << irq_vector_q;
      ack_fire   = (state_q == REQUEST) && cpu_ack;

      // An accepted interrupt clears its own pending bit just like a software
      // clear does; both lose against a fresh request in the same cycle.
      clr_vec    = clear_pending | (ack_fire ? vec_onehot : '0);
      pending_d  = int_req | (pending_q & ~clr_vec);

      // A request is lost only when it lands on a pending bit that is not
      // being cleared this cycle. Only software may clear the sticky flag.
      overrun_d  = (overrun_q & ~clear_pending) | (int_req & pending_q & ~clr_vec);
   end

   // Fixed priority: scanning downward leaves the lowest eligible index.
   always_comb begin
      eligible = pending_q & int_mask;
      prio_idx = '0;
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            prio_idx = VECTOR_WIDTH'(i);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // The presented request is withdrawn when interrupts are globally
      // disabled, its source is masked, or its pending bit is going away this
      // cycle (software clear without a simultaneous re-request).
      withdraw = ~global_enable
               | ~(|(vec_onehot & int_mask))
               | ~(|(vec_onehot & pending_d));

      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (global_enable && (|eligible)) begin
               state_d = REQUEST;
            end
         end
         REQUEST: begin
            // Acceptance beats withdrawal when both happen together.
            if (cpu_ack) begin
               state_d = SERVICE;
            end else if (withdraw) begin
               state_d = IDLE;
            end
         end
         SERVICE: begin
            // global_enable is deliberately ignored here: service runs to eoi.
            if (cpu_eoi) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: output logic (all outputs are registered from these values)
   // ---------------------------------------------------------------------------
   always_comb begin
      irq_d        = (state_d == REQUEST);
      in_service_d = (state_d == SERVICE);

      // The vector is captured only on dispatch, so a higher-priority arrival
      // during REQUEST cannot change what the CPU is about to acknowledge,
      // and it keeps naming the serviced source through SERVICE.
      irq_vector_d = irq_vector_q;
      if ((state_q == IDLE) && (state_d == REQUEST)) begin
         irq_vector_d = prio_idx;
      end
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         irq_q        <= 1'b0;
         irq_vector_q <= '0;
         pending_q    <= '0;
         overrun_q    <= '0;
         in_service_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         irq_q        <= irq_d;
         irq_vector_q <= irq_vector_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         in_service_q <= in_service_d;
      end
   end

   assign irq        = irq_q;
   assign irq_vector = irq_vector_q;
   assign pending    = pending_q;
   assign overrun    = overrun_q;
   assign in_service = in_service_q;

endmodule

// File: tb/tb_ext_int_controller.sv
// -----------------------------------------------------------------------------
// tb_ext_int_controller
//
// Directed scenarios followed by randomized traffic. A behavioural model held
// as plain integers (pending/overrun bitmasks, a mode number and a vector)
// predicts every output after every clock edge.
// -----------------------------------------------------------------------------
module tb_ext_int_controller;

   localparam int N  = 4;
   localparam int VW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  int_req;
   logic          global_enable;
   logic [N-1:0]  int_mask;
   logic [N-1:0]  clear_pending;
   logic          cpu_ack;
   logic          cpu_eoi;
   logic          irq;
   logic [VW-1:0] irq_vector;
   logic [N-1:0]  pending;
   logic [N-1:0]  overrun;
   logic          in_service;

   ext_int_controller #(.NUM_SOURCES(N), .VECTOR_WIDTH(VW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .int_req       (int_req),
      .global_enable (global_enable),
      .int_mask      (int_mask),
      .clear_pending (clear_pending),
      .cpu_ack       (cpu_ack),
      .cpu_eoi       (cpu_eoi),
      .irq           (irq),
      .irq_vector    (irq_vector),
      .pending       (pending),
      .overrun       (overrun),
      .in_service    (in_service)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: mode 0 = idle, 1 = presenting, 2 = servicing.
   int m_pend, m_ovr, m_mode, m_vec, m_irq, m_insvc;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_ovr = 0; m_mode = 0; m_vec = 0; m_irq = 0; m_insvc = 0;
   endtask

   // One clock edge of the specified behaviour, from the inputs seen there.
   task automatic model_step(input int r, input int en, input int m,
                             input int c, input int a, input int e);
      int cleared, new_pend, elig, idx;
      cleared  = c;
      if (m_mode == 1 && a != 0) cleared = cleared | (1 << m_vec);
      new_pend = r | (m_pend & ~cleared);
      m_ovr    = (m_ovr & ~c) | (r & m_pend & ~cleared);
      elig     = m_pend & m;
      if (m_mode == 0) begin
         if (en != 0 && elig != 0) begin
            idx = 0;
            while (((elig >> idx) & 1) == 0) idx++;
            m_vec = idx; m_mode = 1; m_irq = 1;
         end
      end else if (m_mode == 1) begin
         if (a != 0) begin
            m_mode = 2; m_irq = 0; m_insvc = 1;
         end else if (en == 0 || ((m >> m_vec) & 1) == 0 || ((new_pend >> m_vec) & 1) == 0) begin
            m_mode = 0; m_irq = 0;
         end
      end else begin
         if (e != 0) begin
            m_mode = 0; m_insvc = 0;
         end
      end
      m_pend = new_pend & 15;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".irq"},     32'(irq),        32'(m_irq));
      chk({tag, ".vector"},  32'(irq_vector), 32'(m_vec));
      chk({tag, ".pending"}, 32'(pending),    32'(m_pend));
      chk({tag, ".overrun"}, 32'(overrun),    32'(m_ovr));
      chk({tag, ".insvc"},   32'(in_service), 32'(m_insvc));
   endtask

   // Drive one cycle of inputs at the falling edge, advance through the
   // rising edge, then compare at the next falling edge.
   task automatic cycle(input string tag, input logic [3:0] r, input logic en,
                        input logic [3:0] m, input logic [3:0] c,
                        input logic a, input logic e);
      int_req = r; global_enable = en; int_mask = m;
      clear_pending = c; cpu_ack = a; cpu_eoi = e;
      @(posedge clk);
      model_step(int'(r), int'(en), int'(m), int'(c), int'(a), int'(e));
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int k = 0; k < n; k++) cycle(tag, 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
   endtask

   logic [3:0] rm, rr, rc;
   logic       re, ra, rv;

   initial begin
      rst_n = 1'b0;
      int_req = '0; global_enable = 1'b0; int_mask = '0;
      clear_pending = '0; cpu_ack = 1'b0; cpu_eoi = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      chk("reset_pending_const", 32'(pending), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single source, full latency and handshake
      cycle("t1_pulse", 4'b0100, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
      chk("t1_pending_at_1", 32'(pending), 32'h4);
      chk("t1_irq_low_at_1", 32'(irq), 32'd0);
      idle("t1_dispatch", 1);
      chk("t1_irq_at_2", 32'(irq), 32'd1);
      chk("t1_vector_at_2", 32'(irq_vector), 32'd2);
      idle("t1_wait", 2);
      cycle("t1_ack", 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);
      chk("t1_ack_pending", 32'(pending), 32'd0);
      chk("t1_ack_insvc", 32'(in_service), 32'd1);
      chk("t1_ack_irq", 32'(irq), 32'd0);
      idle("t1_svc", 2);
      cycle("t1_eoi", 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1);
      chk("t1_eoi_insvc", 32'(in_service), 32'd0);
      idle("t1_after", 1);

      // Priority between simultaneous requests
      cycle("t2_pulse", 4'b1010, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
      idle("t2_dispatch", 1);
      chk("t2_first_vector", 32'(irq_vector), 32'd1);
      cycle("t2_ack1", 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);
      chk("t2_pending_after_ack1", 32'(pending), 32'h8);
      cycle("t2_eoi1", 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1);
      chk("t2_no_irq_at_eoi", 32'(irq), 32'd0);
      idle("t2_dispatch2", 1);
      chk("t2_second_irq", 32'(irq), 32'd1);
      chk("t2_second_vector", 32'(irq_vector), 32'd3);
      cycle("t2_ack3", 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);
      chk("t2_pending_empty", 32'(pending), 32'd0);
      cycle("t2_eoi3", 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1);

      // Masked source latches but is not dispatched; enable withdrawal
      cycle("t3_masked", 4'b0001, 1'b1, 4'b1110, 4'b0000, 1'b0, 1'b0);
      cycle("t3_masked_wait", 4'b0000, 1'b1, 4'b1110, 4'b0000, 1'b0, 1'b0);
      cycle("t3_masked_wait", 4'b0000, 1'b1, 4'b1110, 4'b0000, 1'b0, 1'b0);
      chk("t3_masked_pending", 32'(pending), 32'h1);
      chk("t3_masked_no_irq", 32'(irq), 32'd0);
      cycle("t3_clear0", 4'b0100, 1'b1, 4'b1110, 4'b0001, 1'b0, 1'b0);
      cycle("t3_dispatch", 4'b0000, 1'b1, 4'b1110, 4'b0000, 1'b0, 1'b0);
      chk("t3_irq_up", 32'(irq), 32'd1);
      cycle("t3_disable", 4'b0000, 1'b0, 4'b1110, 4'b0000, 1'b0, 1'b0);
      chk("t3_irq_withdrawn", 32'(irq), 32'd0);
      chk("t3_pending_kept", 32'(pending), 32'h4);
      cycle("t3_reenable", 4'b0000, 1'b1, 4'b1110, 4'b0000, 1'b0, 1'b0);
      chk("t3_irq_back", 32'(irq), 32'd1);
      cycle("t3_ack", 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);
      cycle("t3_eoi", 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1);

      // Overrun and its software clear
      cycle("t4_first", 4'b1000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
      cycle("t4_second", 4'b1000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
      chk("t4_overrun_set", 32'(overrun), 32'h8);
      cycle("t4_clear", 4'b0000, 1'b1, 4'b1111, 4'b1000, 1'b0, 1'b0);
      chk("t4_pending_clr", 32'(pending), 32'd0);
      chk("t4_overrun_clr", 32'(overrun), 32'd0);
      idle("t4_settle", 1);

      // Request colliding with its own ack
      cycle("t5_pulse", 4'b0010, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
      idle("t5_dispatch", 1);
      cycle("t5_ack_set", 4'b0010, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);
      chk("t5_pending_kept", 32'(pending), 32'h2);
      chk("t5_insvc", 32'(in_service), 32'd1);
      cycle("t5_eoi", 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1);
      idle("t5_redispatch", 1);
      chk("t5_represent_irq", 32'(irq), 32'd1);
      chk("t5_represent_vec", 32'(irq_vector), 32'd1);
      cycle("t5_ack2", 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);

      // Asynchronous reset in the middle of service
      cycle("t6_pulse", 4'b1001, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
      chk("t6_in_service_pre", 32'(in_service), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("t6_async_irq", 32'(irq), 32'd0);
      chk("t6_async_insvc", 32'(in_service), 32'd0);
      chk("t6_async_pending", 32'(pending), 32'd0);
      chk("t6_async_overrun", 32'(overrun), 32'd0);
      chk("t6_async_vector", 32'(irq_vector), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle("t6_stray", 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1);
      chk("t6_stray_insvc", 32'(in_service), 32'd0);
      chk("t6_stray_irq", 32'(irq), 32'd0);
      idle("t6_settle", 2);

      // Randomized traffic
      rm = 4'b1111;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 49) == 0) rm = 4'($urandom_range(0, 15));
         rr = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         rc = ($urandom_range(0, 14) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         rv = ($urandom_range(0, 9) != 0);
         ra = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         re = (m_mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
         cycle("rand", rr, rv, rm, rc, ra, re);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ext_int_controller.md
Name: ext_int_controller

Overview:
- Sits directly downstream of the per-pin external interrupt handlers. Each handler produces a one-cycle interrupt_request pulse.
- Latches these pulses into per-source pending flags, applies a mask and a global enable, and picks the highest-priority pending source.
- Presents that source to the CPU core through an irq/ack/eoi handshake.
- Tracks lost (overrun) requests per source.

Parameters:
- NUM_SOURCES, 4, number of interrupt sources (2..16).
- VECTOR_WIDTH, $clog2(NUM_SOURCES), width of the source index output.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- int_req  input  NUM_SOURCES  one-cycle request pulses, one bit per source; bit i comes from handler i's interrupt_request
- global_enable  input  1  master interrupt enable (CPU status bit)
- int_mask  input  NUM_SOURCES  1 = source enabled for dispatch
- clear_pending  input  NUM_SOURCES  software clear of pending and overrun bits, one-cycle pulse per bit
- cpu_ack  input  1  CPU accepts the presented interrupt
- cpu_eoi  input  1  end of interrupt (return from ISR)
- irq  output  1  interrupt request to CPU
- irq_vector  output  VECTOR_WIDTH  index of the presented / in-service source
- pending  output  NUM_SOURCES  pending flags
- overrun  output  NUM_SOURCES  sticky lost-request flags
- in_service  output  1  high while an ISR is active

Behaviour:
- Reset: asynchronous on rst_n low. State returns to IDLE; irq, irq_vector, pending, overrun and in_service all go to 0.
- Pending latch, evaluated each cycle per bit i:
  - int_req[i]=1 sets pending[i] on the next edge.
  - clear_pending[i]=1 clears it.
  - An ack of source i clears it.
  - If a set and a clear (software or ack) happen in the same cycle, the set wins.
  - Masked sources still latch pending.
- Overrun: int_req[i]=1 while pending[i] is already 1 (and not cleared that cycle) sets overrun[i]. overrun[i] is sticky and is cleared only by clear_pending[i].
- Eligible set: pending & int_mask. Fixed priority, lowest index highest.
- FSM states: IDLE, REQUEST, SERVICE.
- IDLE:
  - If global_enable=1 and the eligible set is non-zero, go to REQUEST.
  - On that transition, register irq_vector = highest-priority eligible index and set irq=1.
  - Latency: int_req pulse at edge t -> pending at t+1 -> irq=1 at t+2.
- REQUEST:
  - irq=1. irq_vector is frozen; a higher-priority arrival does not change it.
  - If cpu_ack=1: clear pending[irq_vector], set irq=0 and in_service=1, go to SERVICE.
  - Else, if global_enable=0 or the presented source has been masked or cleared: irq=0, go to IDLE with pending unchanged.
  - ack takes precedence over this withdrawal in the same cycle.
- SERVICE:
  - irq=0, in_service=1, irq_vector holds the serviced index. No nesting.
  - cpu_eoi=1 sets in_service=0 and goes to IDLE.
  - A new dispatch can assert irq no earlier than 1 cycle after eoi.
  - global_enable=0 does not abort service.
- Ignored inputs: cpu_ack outside REQUEST and cpu_eoi outside SERVICE have no effect.
- Reset mid-operation (any state) returns to IDLE immediately. Requests are not preserved.
- All outputs are registered.

Test Plan:
- Single source, all masks 1, enable=1: pulse int_req=4'b0100 at cycle 0 -> pending=0100 at 1, irq=1 with vector=2 at 2. ack at 5 -> pending=0000, irq=0, in_service=1. eoi at 8 -> in_service=0 and IDLE at 9.
- Priority: same-cycle pulses 4'b1010 -> vector=1 presented first. After ack+eoi, vector=3 is presented; pending goes 1010 -> 1000 -> 0000.
- Mask and enable: int_mask=4'b1110 with pulse on bit 0 -> pending[0]=1, irq stays 0. global_enable=0 during REQUEST -> irq drops next cycle and pending is kept. Re-enable -> irq returns.
- Overrun: two pulses on bit 3 with no ack between -> overrun=1000. clear_pending=1000 -> pending[3]=0 and overrun[3]=0.
- Set/clear collision: int_req[1] in the same cycle as ack of source 1 -> pending[1] stays 1, and the source is re-presented after eoi.
- Async reset: assert rst_n=0 mid-SERVICE between clock edges -> all outputs 0 immediately. A later stray cpu_eoi or cpu_ack has no effect.
